alu_arb: RTL

ALU_ARB -- requirements
Module: alu_arb

---
 rtl/alu_arb.sv | 114 +++++++++++
 1 files changed

// File: rtl/alu_arb.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Grant, execute and complete take one cycle each: one operation per 3 cycles.
module alu_arb #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             REQ0,
  input  logic             REQ1,
  input  logic [2:0]       MODE0,
  input  logic [2:0]       MODE1,
  input  logic [WIDTH-1:0] A0,
  input  logic [WIDTH-1:0] B0,
  input  logic [WIDTH-1:0] A1,
  input  logic [WIDTH-1:0] B1,
  input  logic             CIN0,
  input  logic             CIN1,
  output logic             ACK0,
  output logic             ACK1,
  output logic [WIDTH-1:0] X_OUT,
  output logic             C_OUT,
  output logic             VALID,
  output logic             VALID_ID,
  output logic [2:0]       ALU_MODE,
  output logic [WIDTH-1:0] ALU_A,
  output logic [WIDTH-1:0] ALU_B,
  output logic             ALU_CIN,
  input  logic [WIDTH-1:0] ALU_X,
  input  logic             ALU_COUT
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  logic   pri;
  logic   grantee;

  logic             any_req;
  logic             gnt;
  logic [2:0]       sel_mode;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic             sel_cin;

  // PRI only matters under contention; a lone requester always wins.
  always_comb begin
    any_req = REQ0 | REQ1;
    gnt     = 1'b0;
    if (REQ0 && REQ1) gnt = pri;
    else if (REQ1)    gnt = 1'b1;
    sel_mode = gnt ? MODE1 : MODE0;
    sel_a    = gnt ? A1    : A0;
    sel_b    = gnt ? B1    : B0;
    sel_cin  = gnt ? CIN1  : CIN0;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= IDLE;
      pri      <= 1'b0;
      grantee  <= 1'b0;
      ACK0     <= 1'b0;
      ACK1     <= 1'b0;
      VALID    <= 1'b0;
      VALID_ID <= 1'b0;
      X_OUT    <= '0;
      C_OUT    <= 1'b0;
      ALU_MODE <= 3'b000;
      ALU_A    <= '0;
      ALU_B    <= '0;
      ALU_CIN  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any_req) begin
            ALU_MODE <= sel_mode;
            ALU_A    <= sel_a;
            ALU_B    <= sel_b;
            ALU_CIN  <= sel_cin;
            grantee  <= gnt;
            pri      <= ~gnt;
            state    <= EXEC;
          end
        end
        EXEC: begin
          X_OUT    <= ALU_X;
          C_OUT    <= ALU_COUT;
          VALID_ID <= grantee;
          VALID    <= 1'b1;
          ACK0     <= ~grantee;
          ACK1     <= grantee;
          state    <= DONE;
        end
        DONE: begin
          VALID <= 1'b0;
          ACK0  <= 1'b0;
          ACK1  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          VALID <= 1'b0;
          ACK0  <= 1'b0;
          ACK1  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
